lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Single-outstanding load/store controller that owns the core's data-memory port (address/read_enable/read_valid/write_data/write_enable/strb/write_ready). It accepts one memory micro-op from the issue path, sequences the memory handshake, and aligns and extends load data. It returns a tagged writeback (phys_rd, bank_addr, rob_addr) to the WB stage. It detects misalignment and supports pipeline flush.

Parameters:
PHYS_REGS_ADDR_WIDTH, 6, physical register tag width
ROB_ADDR_WIDTH, 3, ROB entry index width
BANK_WIDTH, 2, ROB bank address width (equals DISPATCH_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  micro-op offered
req_ready  out  1  controller can accept
req_is_store  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  zero-extend load (LBU/LHU)
req_base  in  32  rs1 value
req_offset  in  32  immediate
req_store_data  in  32  rs2 value (low bits significant)
req_phys_rd  in  PHYS_REGS_ADDR_WIDTH  destination tag
req_bank_addr  in  BANK_WIDTH  ROB bank
req_rob_addr  in  ROB_ADDR_WIDTH  ROB index
flush  in  1  squash in-flight op
address  out  32  memory address (word-aligned: ea & ~3)
read_enable  out  1  load request
read_data  in  32  memory word
read_valid  in  1  read_data valid
write_data  out  32  lane-shifted store data
write_enable  out  1  store request
strb  out  4  byte enables
write_ready  in  1  store accepted
resp_valid  out  1  result available
resp_ready  in  1  WB consumes result
resp_data  out  32  extended load data; 0 for stores/faults
resp_phys_rd  out  PHYS_REGS_ADDR_WIDTH  echoed tag
resp_bank_addr  out  BANK_WIDTH  echoed bank
resp_rob_addr  out  ROB_ADDR_WIDTH  echoed ROB index
resp_is_store  out  1  echoed op kind
resp_misaligned  out  1  address fault, no memory access made

Behaviour:
- rst low (async): state=IDLE; every output 0, req_ready included. First req_ready=1 is in the first clock after rst deasserts. Reset mid-op abandons the handshake; no response is produced.
- FSM states: IDLE, READ, WRITE, RESP. All outputs except req_ready come from registers. req_ready = (state==IDLE) & !flush.
- Accept: in IDLE with req_valid & req_ready. Latch ea = (req_base+req_offset) mod 2^32, plus all tags/controls.
- Misaligned = size==3 | (size==1 & ea[0]) | (size==2 & ea[1:0]!=0). If misaligned: go to RESP with resp_misaligned=1 and resp_data=0. No read_enable/write_enable is ever asserted.
- Load, aligned: go to READ. read_enable=1 and address=ea&~3 from the cycle after accept, held stable until read_valid is sampled 1.
  - Extraction: shift read_data right by ea[1:0]*8, then mask to size.
  - Sign-extend from bit 7/15 unless req_unsigned. Word passes through.
  - Latch the result; go to RESP with read_enable=0 in that cycle. read_valid outside READ is ignored.
- Store, aligned: go to WRITE.
  - write_data = store_data << ea[1:0]*8 (byte lane-replicated form not required).
  - strb: byte 4'b0001<<ea[1:0]; half 4'b0011<<ea[1:0]; word 4'b1111.
  - Hold write_enable/address/data/strb until write_ready is sampled 1, then go to RESP with resp_data=0.
- RESP: resp_valid=1 with stable fields until resp_ready=1, then go to IDLE.
  - No accept in that same cycle; minimum occupancy is accept + 1 access cycle + 1 resp cycle.
- flush:
  - IDLE: blocks accept.
  - READ/WRITE: the memory handshake is not aborted; on completion go to IDLE without a response.
  - RESP: drop the response (resp_valid=0 next cycle) and go to IDLE.
  - A flush arriving after a flushed READ/WRITE completes is harmless.
- Address arithmetic wraps silently; wrap is not a fault.

Test Plan:
- LW base=0x1000, off=0x4, read_valid 2 cycles after read_enable, read_data=0xDEADBEEF -> address=0x1004; resp_data=0xDEADBEEF; resp_valid exactly one cycle after read_valid; tags echoed.
- LB ea=0x1003 with read_data=0x80FF_0000 -> resp_data=0xFFFFFF80; the same op with req_unsigned=1 -> 0x00000080.
- SH ea=0x2002, store_data=0x1234ABCD, write_ready delayed 3 cycles -> address=0x2000, strb=4'b1100, write_data[31:16]=0xABCD, held stable all 3 cycles; resp_valid, resp_is_store=1.
- LW ea=0x3002 and SH ea=0x3001 -> read_enable/write_enable never asserted; resp_misaligned=1 one cycle after accept.
- resp_ready held 0 for 5 cycles -> resp fields stable and req_ready=0 throughout; IDLE and req_ready=1 the cycle after resp_ready=1.
- flush during READ, then read_valid -> no resp_valid, return to IDLE; rst pulsed low during WRITE -> write_enable=0 immediately (async), no response.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store controller for the data-memory port.
// Accepts one memory micro-op, runs the read or write handshake, aligns and extends
// load data, and returns a tagged response to writeback.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_*                       micro-op from issue (valid/ready handshake)
//   flush                       squash the in-flight op
//   address, read_enable,       memory request (word-aligned address)
//   read_data, read_valid       memory load return
//   write_data, write_enable,   memory store request (lane-shifted data, byte enables)
//   strb, write_ready
//   resp_*                      tagged result to writeback (valid/ready handshake)
module lsu_mem_ctrl #(
  parameter int unsigned PHYS_REGS_ADDR_WIDTH = 6,
  parameter int unsigned ROB_ADDR_WIDTH       = 3,
  parameter int unsigned BANK_WIDTH           = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_is_store,
  input  logic [1:0]                      req_size,
  input  logic                            req_unsigned,
  input  logic [31:0]                     req_base,
  input  logic [31:0]                     req_offset,
  input  logic [31:0]                     req_store_data,
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] req_phys_rd,
  input  logic [BANK_WIDTH-1:0]           req_bank_addr,
  input  logic [ROB_ADDR_WIDTH-1:0]       req_rob_addr,
  input  logic                            flush,
  output logic [31:0]                     address,
  output logic                            read_enable,
  input  logic [31:0]                     read_data,
  input  logic                            read_valid,
  output logic [31:0]                     write_data,
  output logic                            write_enable,
  output logic [3:0]                      strb,
  input  logic                            write_ready,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [31:0]                     resp_data,
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] resp_phys_rd,
  output logic [BANK_WIDTH-1:0]           resp_bank_addr,
  output logic [ROB_ADDR_WIDTH-1:0]       resp_rob_addr,
  output logic                            resp_is_store,
  output logic                            resp_misaligned
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e state_q, state_d;
  logic   live_q;  // keeps req_ready low until the first clock after reset
  logic   flushed_q, flushed_d;
  logic [1:0] size_q, size_d;
  logic [1:0] off_q, off_d;
  logic       uns_q, uns_d;

  logic [31:0] address_q, address_d;
  logic        read_enable_q, read_enable_d;
  logic        write_enable_q, write_enable_d;
  logic [31:0] write_data_q, write_data_d;
  logic [3:0]  strb_q, strb_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd_q, phys_rd_d;
  logic [BANK_WIDTH-1:0]           bank_q, bank_d;
  logic [ROB_ADDR_WIDTH-1:0]       rob_q, rob_d;
  logic        is_store_q, is_store_d;
  logic        mis_q, mis_d;

  logic [31:0] ea;
  logic        misaligned;
  logic        accept;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign ea        = req_base + req_offset;
  assign req_ready = live_q & (state_q == StIdle) & ~flush;
  assign accept    = req_valid & req_ready;

  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = ea[0];
      2'd2:    misaligned = (ea[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign shifted = read_data >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    load_val = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    flushed_d      = flushed_q;
    size_d         = size_q;
    off_d          = off_q;
    uns_d          = uns_q;
    address_d      = address_q;
    read_enable_d  = read_enable_q;
    write_enable_d = write_enable_q;
    write_data_d   = write_data_q;
    strb_d         = strb_q;
    resp_valid_d   = resp_valid_q;
    resp_data_d    = resp_data_q;
    phys_rd_d      = phys_rd_q;
    bank_d         = bank_q;
    rob_d          = rob_q;
    is_store_d     = is_store_q;
    mis_d          = mis_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          phys_rd_d   = req_phys_rd;
          bank_d      = req_bank_addr;
          rob_d       = req_rob_addr;
          is_store_d  = req_is_store;
          size_d      = req_size;
          uns_d       = req_unsigned;
          off_d       = ea[1:0];
          flushed_d   = 1'b0;
          mis_d       = misaligned;
          resp_data_d = '0;
          if (misaligned) begin
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end else if (req_is_store) begin
            address_d      = {ea[31:2], 2'b00};
            write_data_d   = req_store_data << {ea[1:0], 3'b000};
            strb_d         = (req_size == 2'd0) ? (4'b0001 << ea[1:0]) :
                             (req_size == 2'd1) ? (4'b0011 << ea[1:0]) : 4'b1111;
            write_enable_d = 1'b1;
            state_d        = StWrite;
          end else begin
            address_d     = {ea[31:2], 2'b00};
            read_enable_d = 1'b1;
            state_d       = StRead;
          end
        end
      end
      StRead: begin
        flushed_d = flushed_q | flush;
        if (read_valid) begin
          read_enable_d = 1'b0;
          if (flushed_q || flush) begin
            state_d = StIdle;
          end else begin
            resp_data_d  = load_val;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end
        end
      end
      StWrite: begin
        flushed_d = flushed_q | flush;
        if (write_ready) begin
          write_enable_d = 1'b0;
          if (flushed_q || flush) begin
            state_d = StIdle;
          end else begin
            resp_data_d  = '0;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end
        end
      end
      StResp: begin
        if (flush || resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      live_q         <= 1'b0;
      flushed_q      <= 1'b0;
      size_q         <= '0;
      off_q          <= '0;
      uns_q          <= 1'b0;
      address_q      <= '0;
      read_enable_q  <= 1'b0;
      write_enable_q <= 1'b0;
      write_data_q   <= '0;
      strb_q         <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      phys_rd_q      <= '0;
      bank_q         <= '0;
      rob_q          <= '0;
      is_store_q     <= 1'b0;
      mis_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      live_q         <= 1'b1;
      flushed_q      <= flushed_d;
      size_q         <= size_d;
      off_q          <= off_d;
      uns_q          <= uns_d;
      address_q      <= address_d;
      read_enable_q  <= read_enable_d;
      write_enable_q <= write_enable_d;
      write_data_q   <= write_data_d;
      strb_q         <= strb_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      phys_rd_q      <= phys_rd_d;
      bank_q         <= bank_d;
      rob_q          <= rob_d;
      is_store_q     <= is_store_d;
      mis_q          <= mis_d;
    end
  end

  assign address         = address_q;
  assign read_enable     = read_enable_q;
  assign write_enable    = write_enable_q;
  assign write_data      = write_data_q;
  assign strb            = strb_q;
  assign resp_valid      = resp_valid_q;
  assign resp_data       = resp_data_q;
  assign resp_phys_rd    = phys_rd_q;
  assign resp_bank_addr  = bank_q;
  assign resp_rob_addr   = rob_q;
  assign resp_is_store   = is_store_q;
  assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a directed vector table, randomized ops
// checked against a byte-level reference model, and hand-written flush/reset sequences.
module tb_lsu_mem_ctrl;

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_base, req_offset, req_store_data;
  logic [5:0]  req_phys_rd;
  logic [1:0]  req_bank_addr;
  logic [2:0]  req_rob_addr;
  logic        flush;
  logic [31:0] address, read_data, write_data, resp_data;
  logic        read_enable, read_valid, write_enable, write_ready;
  logic [3:0]  strb;
  logic        resp_valid, resp_ready, resp_is_store, resp_misaligned;
  logic [5:0]  resp_phys_rd;
  logic [1:0]  resp_bank_addr;
  logic [2:0]  resp_rob_addr;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_base(req_base),
    .req_offset(req_offset), .req_store_data(req_store_data), .req_phys_rd(req_phys_rd),
    .req_bank_addr(req_bank_addr), .req_rob_addr(req_rob_addr), .flush(flush),
    .address(address), .read_enable(read_enable), .read_data(read_data),
    .read_valid(read_valid), .write_data(write_data), .write_enable(write_enable),
    .strb(strb), .write_ready(write_ready), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_phys_rd(resp_phys_rd),
    .resp_bank_addr(resp_bank_addr), .resp_rob_addr(resp_rob_addr),
    .resp_is_store(resp_is_store), .resp_misaligned(resp_misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] sd;
    logic [31:0] rd;
    int          lat;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: works on the memory word as a byte array and integer values.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    longint ea = longint'(v.base) + longint'(v.offset);
    int a, n;
    longint val;
    ea = ea % 64'h1_0000_0000;
    a = int'(ea % 4);
    n = (v.size == 2'd3) ? 0 : (1 << v.size);
    r.exp_mis   = (n == 0) || ((ea % n) != 0);
    r.exp_data  = '0;
    r.exp_strb  = '0;
    r.exp_wdata = '0;
    if (!r.exp_mis) begin
      if (v.is_store) begin
        r.exp_strb  = 4'(((1 << n) - 1) << a);
        r.exp_wdata = 32'(longint'(v.sd) << (8 * a));
      end else begin
        val = 0;
        for (int k = 0; k < n; k++) val += longint'((v.rd >> (8 * (a + k))) & 32'hFF) << (8 * k);
        if (!v.uns && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= longint'(1) << (8 * n);
        r.exp_data = 32'(val);
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] base, input logic [31:0] off,
                           input logic [31:0] sd);
    req_is_store   = st;
    req_size       = sz;
    req_unsigned   = uns;
    req_base       = base;
    req_offset     = off;
    req_store_data = sd;
  endtask

  task automatic run_op(input vec_t v);
    logic [31:0] eaw;
    logic [5:0]  prd;
    logic [1:0]  bnk;
    logic [2:0]  rob;
    int          guard;
    eaw = (v.base + v.offset) & ~32'd3;
    prd = 6'($urandom);
    bnk = 2'($urandom);
    rob = 3'($urandom);
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("accept_ready", 64'(req_ready), 64'd1);
    drive_req(v.is_store, v.size, v.uns, v.base, v.offset, v.sd);
    req_phys_rd   = prd;
    req_bank_addr = bnk;
    req_rob_addr  = rob;
    req_valid     = 1'b1;
    tick();
    req_valid = 1'b0;
    if (v.exp_mis) begin
      chk("mis_resp_valid", 64'(resp_valid), 64'd1);
      chk("mis_no_mem", 64'({read_enable, write_enable}), 64'd0);
    end else if (!v.is_store) begin
      for (int i = 0; i <= v.lat; i++) begin
        chk("load_read_enable", 64'(read_enable), 64'd1);
        chk("load_address", 64'(address), 64'(eaw));
        chk("load_no_early_resp", 64'(resp_valid), 64'd0);
        read_valid = (i == v.lat);
        read_data  = (i == v.lat) ? v.rd : $urandom;
        tick();
      end
      read_valid = 1'b0;
      chk("load_done_re_low", 64'(read_enable), 64'd0);
      chk("load_resp_valid", 64'(resp_valid), 64'd1);
    end else begin
      for (int i = 0; i <= v.lat; i++) begin
        chk("store_write_enable", 64'(write_enable), 64'd1);
        chk("store_address", 64'(address), 64'(eaw));
        chk("store_strb", 64'(strb), 64'(v.exp_strb));
        chk("store_wdata", 64'(write_data), 64'(v.exp_wdata));
        write_ready = (i == v.lat);
        tick();
      end
      write_ready = 1'b0;
      chk("store_done_we_low", 64'(write_enable), 64'd0);
      chk("store_resp_valid", 64'(resp_valid), 64'd1);
    end
    for (int h = 0; h <= v.hold; h++) begin
      chk("resp_data", 64'(resp_data), 64'(v.exp_data));
      chk("resp_flags", 64'({resp_is_store, resp_misaligned}), 64'({v.is_store, v.exp_mis}));
      chk("resp_tags", 64'({resp_phys_rd, resp_bank_addr, resp_rob_addr}), 64'({prd, bnk, rob}));
      chk("resp_ready_low", 64'(req_ready), 64'd0);
      if (h < v.hold) begin
        tick();
        chk("resp_valid_held", 64'(resp_valid), 64'd1);
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_done_valid_low", 64'(resp_valid), 64'd0);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    rst = 1'b1; req_valid = 0; flush = 0; read_valid = 0; write_ready = 0; resp_ready = 0;
    read_data = 0; req_phys_rd = 0; req_bank_addr = 0; req_rob_addr = 0;
    drive_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0);

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_ctrl", 64'({req_ready, read_enable, write_enable, resp_valid, resp_is_store,
                         resp_misaligned, strb}), 64'd0);
    chk("rst_addr_data", {address, write_data}, 64'd0);
    chk("rst_resp", 64'({resp_data, resp_phys_rd, resp_bank_addr, resp_rob_addr}), 64'd0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ready_before_first_clk", 64'(req_ready), 64'd0);
    tick();
    chk("ready_first_clk", 64'(req_ready), 64'd1);

    // st, size, uns, base, offset, sd, rd, lat, hold, exp_data, exp_mis, exp_strb, exp_wdata
    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h4, 32'h0, 32'hDEADBEEF, 2, 0,
                32'hDEADBEEF, 1'b0, 4'h0, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h1000, 32'h3, 32'h0, 32'h80FF0000, 0, 0,
                32'hFFFFFF80, 1'b0, 4'h0, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h1000, 32'h3, 32'h0, 32'h80FF0000, 1, 0,
                32'h00000080, 1'b0, 4'h0, 32'h0};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 32'h2000, 32'h2, 32'h1234ABCD, 32'h0, 3, 0,
                32'h0, 1'b0, 4'b1100, 32'hABCD0000};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h3000, 32'h2, 32'h0, 32'h0, 0, 0,
                32'h0, 1'b1, 4'h0, 32'h0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h3000, 32'h1, 32'h5555, 32'h0, 0, 0,
                32'h0, 1'b1, 4'h0, 32'h0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'h4, 32'h0, 32'h80011234, 1, 5,
                32'hFFFF8001, 1'b0, 4'h0, 32'h0};
    tbl[7]  = '{1'b1, 2'd3, 1'b0, 32'h40, 32'h0, 32'h1, 32'h0, 0, 0,
                32'h0, 1'b1, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h100, 32'h2, 32'h0, 32'h80017777, 0, 1,
                32'h00008001, 1'b0, 4'h0, 32'h0};
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h10, 32'h1, 32'h000000A5, 32'h0, 1, 0,
                32'h0, 1'b0, 4'b0010, 32'h0000A500};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h7FFC, 32'h8, 32'hCAFEF00D, 32'h0, 0, 2,
                32'h0, 1'b0, 4'b1111, 32'hCAFEF00D};
    for (int i = 0; i < 11; i++) run_op(tbl[i]);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rv.is_store = 1'($urandom);
      rv.size     = 2'($urandom);
      rv.uns      = 1'($urandom);
      rv.base     = $urandom;
      rv.offset   = $urandom;
      rv.sd       = $urandom;
      rv.rd       = $urandom;
      rv.lat      = int'($urandom_range(0, 3));
      rv.hold     = int'($urandom_range(0, 2));
      run_op(model(rv));
    end

    // Flush in IDLE blocks accept
    drive_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0);
    flush = 1'b1; req_valid = 1'b1;
    #1;
    chk("flush_idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("flush_idle_no_accept", 64'({read_enable, resp_valid}), 64'd0);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_ready_back", 64'(req_ready), 64'd1);

    // Flush during READ: handshake completes, no response
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("flush_read_re", 64'(read_enable), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_read_re_held", 64'(read_enable), 64'd1);
    read_valid = 1'b1; read_data = 32'h12345678;
    tick();
    read_valid = 1'b0;
    chk("flush_read_done", 64'({read_enable, resp_valid}), 64'd0);
    chk("flush_read_idle", 64'(req_ready), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_read_no_resp", 64'(resp_valid), 64'd0);

    // Flush in RESP drops the response
    drive_req(1'b0, 2'd3, 1'b0, 32'h80, 32'h0, 32'h0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("flush_resp_valid", 64'(resp_valid), 64'd1);
    flush = 1'b1;
    tick();
    chk("flush_resp_dropped", 64'(resp_valid), 64'd0);
    flush = 1'b0;
    #1;
    chk("flush_resp_idle", 64'(req_ready), 64'd1);

    // Reset asserted during WRITE
    drive_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h0, 32'hFFFF0000);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rst_write_we", 64'(write_enable), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_write_async", 64'({write_enable, resp_valid, req_ready}), 64'd0);
    chk("rst_write_addr", 64'(address), 64'd0);
    #3 rst = 1'b1;
    #1;
    chk("rst_write_ready_low", 64'(req_ready), 64'd0);
    tick();
    chk("rst_write_ready", 64'(req_ready), 64'd1);
    tick();
    chk("rst_write_no_resp", 64'({resp_valid, write_enable}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
